// File: rtl/m68k_bus_pkg.sv
// Shared types and helpers for the 68000 bus-cycle responder.
package m68k_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    ACK      = 2'd2,
    BERR     = 2'd3
  } state_e;

  localparam logic SEL_ROM = 1'b0;
  localparam logic SEL_RAM = 1'b1;

  // True when byte address addr falls in the aligned 2**size_log2 window at base.
  function automatic logic region_hit(input logic [23:0] addr,
                                      input logic [23:0] base,
                                      input int unsigned size_log2);
    return (addr >> size_log2) == (base >> size_log2);
  endfunction

endpackage

// File: rtl/m68k_bus_ctrl.sv
// Bus-cycle responder behind the fx68k core: turns AS/UDS/LDS/RW cycles into
// single-word requests on a synchronous memory port and answers with DTACKn
// or BERRn.
module m68k_bus_ctrl #(
  parameter logic [23:0] ROM_BASE       = 24'h000000,
  parameter int unsigned ROM_SIZE_LOG2  = 16,
  parameter logic [23:0] RAM_BASE       = 24'h100000,
  parameter int unsigned RAM_SIZE_LOG2  = 17,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        i_CLOCK,
  input  logic        i_RESET,
  input  logic        i_AS,
  input  logic        i_UDS,
  input  logic        i_LDS,
  input  logic        i_RW,
  input  logic [22:0] i_ADDR,
  input  logic [15:0] i_DATA_W,
  output logic [15:0] o_DATA_R,
  output logic        o_DTACK,
  output logic        o_BERR,
  output logic        o_MEM_REQ,
  output logic        o_MEM_WE,
  output logic        o_MEM_SEL,
  output logic [1:0]  o_MEM_BE,
  output logic [22:0] o_MEM_ADDR,
  output logic [15:0] o_MEM_WDATA,
  input  logic        i_MEM_ACK,
  input  logic [15:0] i_MEM_RDATA
);
  import m68k_bus_pkg::*;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic        dtack_q, dtack_d;
  logic        we_q, we_d;
  logic        sel_q, sel_d;
  logic [1:0]  be_q, be_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  logic [23:0] byte_addr;
  logic        rom_hit, ram_hit, start;

  // Region decode of the live CPU address; ROM wins on overlap.
  always_comb begin
    byte_addr = {i_ADDR, 1'b0};
    rom_hit   = region_hit(byte_addr, ROM_BASE, ROM_SIZE_LOG2);
    ram_hit   = region_hit(byte_addr, RAM_BASE, RAM_SIZE_LOG2);
    start     = !i_AS && (!i_UDS || !i_LDS);
  end

  // State and datapath registers; reset overrides any cycle in flight.
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      dtack_q <= 1'b1;
      we_q    <= 1'b0;
      sel_q   <= SEL_ROM;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      dtack_q <= dtack_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    dtack_d = dtack_q;
    we_d    = we_q;
    sel_d   = sel_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          we_d    = !i_RW;
          be_d    = {~i_UDS, ~i_LDS};
          addr_d  = i_ADDR;
          wdata_d = i_DATA_W;
          cnt_d   = '0;
          abort_d = 1'b0;
          if (rom_hit) begin
            sel_d   = SEL_ROM;
            // ROM writes are acknowledged without touching memory.
            state_d = i_RW ? WAIT_ACK : ACK;
          end else if (ram_hit) begin
            sel_d   = SEL_RAM;
            state_d = WAIT_ACK;
          end else begin
            sel_d   = SEL_ROM;
            state_d = BERR;
          end
        end
      end
      WAIT_ACK: begin
        // An abort must still see the request through; the flag and the live
        // AS both count so a strobe rising on the final edge is honoured.
        if (i_AS) abort_d = 1'b1;
        if (i_MEM_ACK) begin
          if (!we_q) rdata_d = i_MEM_RDATA;
          state_d = (abort_q || i_AS) ? IDLE : ACK;
        end else if (cnt_q == TMO_LAST) begin
          state_d = (abort_q || i_AS) ? IDLE : BERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK: begin
        if (i_AS) begin
          dtack_d = 1'b1;
          state_d = IDLE;
        end else begin
          dtack_d = 1'b0;
        end
      end
      BERR: begin
        if (i_AS) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and registers.
  always_comb begin
    o_MEM_REQ   = (state_q == WAIT_ACK);
    o_BERR      = (state_q != BERR);
    o_DTACK     = dtack_q;
    o_MEM_WE    = we_q;
    o_MEM_SEL   = sel_q;
    o_MEM_BE    = be_q;
    o_MEM_ADDR  = addr_q;
    o_MEM_WDATA = wdata_q;
    o_DATA_R    = rdata_q;
  end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed testbench for m68k_bus_ctrl.
module tb_m68k_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        as_n, uds_n, lds_n, rw;
  logic [22:0] addr;
  logic [15:0] wdata;
  logic [15:0] data_r;
  logic        dtack, berr, req, we, sel;
  logic [1:0]  be;
  logic [22:0] maddr;
  logic [15:0] mwdata;
  logic        mack;
  logic [15:0] mrdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m68k_bus_ctrl #(
    .ROM_BASE(24'h000000),
    .ROM_SIZE_LOG2(16),
    .RAM_BASE(24'h100000),
    .RAM_SIZE_LOG2(17),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_CLOCK(clk), .i_RESET(rst),
    .i_AS(as_n), .i_UDS(uds_n), .i_LDS(lds_n), .i_RW(rw),
    .i_ADDR(addr), .i_DATA_W(wdata),
    .o_DATA_R(data_r), .o_DTACK(dtack), .o_BERR(berr),
    .o_MEM_REQ(req), .o_MEM_WE(we), .o_MEM_SEL(sel), .o_MEM_BE(be),
    .o_MEM_ADDR(maddr), .o_MEM_WDATA(mwdata),
    .i_MEM_ACK(mack), .i_MEM_RDATA(mrdata)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic release_bus();
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1; mack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; release_bus(); addr = '0; wdata = '0; mrdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (dtack !== 1'b1) begin errors++; $display("FAIL reset_dtack: got %b want 1", dtack); end
    checks++; if (berr !== 1'b1) begin errors++; $display("FAIL reset_berr: got %b want 1", berr); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++; if ({we, sel, be} !== 4'b0000) begin errors++; $display("FAIL reset_we_sel_be: got %b want 0000", {we, sel, be}); end
    checks++; if (maddr !== 23'd0 || mwdata !== 16'd0 || data_r !== 16'd0) begin errors++; $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", maddr, mwdata, data_r); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ram_write();
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0;
    addr = 23'h080008; wdata = 16'hBEEF;
    @(negedge clk);
    checks++; if ({req, we, sel} !== 3'b111) begin errors++; $display("FAIL ramwr_req_we_sel: got %b want 111", {req, we, sel}); end
    checks++; if (be !== 2'b11) begin errors++; $display("FAIL ramwr_be: got %b want 11", be); end
    checks++; if (mwdata !== 16'hBEEF) begin errors++; $display("FAIL ramwr_wdata: got %h want BEEF", mwdata); end
    checks++; if (maddr !== 23'h080008) begin errors++; $display("FAIL ramwr_addr: got %h want 080008", maddr); end
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL ramwr_req_held: got %b want 1", req); end
    mack = 1'b1;
    @(negedge clk);
    mack = 1'b0;
    checks++; if (req !== 1'b0 || dtack !== 1'b1) begin errors++; $display("FAIL ramwr_ack_edge: req %b dtack %b want 0 1", req, dtack); end
    @(negedge clk);
    checks++; if (dtack !== 1'b0) begin errors++; $display("FAIL ramwr_dtack_low: got %b want 0", dtack); end
    @(negedge clk);
    checks++; if (dtack !== 1'b0) begin errors++; $display("FAIL ramwr_dtack_hold: got %b want 0", dtack); end
    checks++; if (data_r !== 16'h0000) begin errors++; $display("FAIL ramwr_rdata_kept: got %h want 0000", data_r); end
    release_bus();
    @(negedge clk);
    checks++; if (dtack !== 1'b1 || berr !== 1'b1) begin errors++; $display("FAIL ramwr_release: dtack %b berr %b want 1 1", dtack, berr); end
  endtask

  task automatic test_rom_read();
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b1; rw = 1'b1; addr = 23'h000002;
    @(negedge clk);
    checks++; if ({req, we, sel} !== 3'b100) begin errors++; $display("FAIL romrd_req_we_sel: got %b want 100", {req, we, sel}); end
    checks++; if (be !== 2'b10) begin errors++; $display("FAIL romrd_be: got %b want 10", be); end
    mack = 1'b1; mrdata = 16'h1234;
    @(negedge clk);
    mack = 1'b0; mrdata = 16'hFFFF;
    checks++; if (req !== 1'b0 || dtack !== 1'b1) begin errors++; $display("FAIL romrd_edge2: req %b dtack %b want 0 1", req, dtack); end
    checks++; if (data_r !== 16'h1234) begin errors++; $display("FAIL romrd_capture: got %h want 1234", data_r); end
    @(negedge clk);
    checks++; if (dtack !== 1'b0) begin errors++; $display("FAIL romrd_dtack_latency: got %b want 0", dtack); end
    checks++; if (data_r !== 16'h1234) begin errors++; $display("FAIL romrd_stable: got %h want 1234", data_r); end
    release_bus();
    @(negedge clk);
    checks++; if (dtack !== 1'b1) begin errors++; $display("FAIL romrd_release: got %b want 1", dtack); end
  endtask

  task automatic test_rom_write();
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b0; addr = 23'h000000; wdata = 16'h5555;
    @(negedge clk);
    checks++; if (req !== 1'b0 || dtack !== 1'b1) begin errors++; $display("FAIL romwr_edge1: req %b dtack %b want 0 1", req, dtack); end
    @(negedge clk);
    checks++; if (req !== 1'b0 || dtack !== 1'b0) begin errors++; $display("FAIL romwr_dtack: req %b dtack %b want 0 0", req, dtack); end
    checks++; if (data_r !== 16'h1234) begin errors++; $display("FAIL romwr_rdata_kept: got %h want 1234", data_r); end
    release_bus();
    @(negedge clk);
    checks++; if (dtack !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL romwr_release: dtack %b req %b want 1 0", dtack, req); end
  endtask

  task automatic test_unmapped();
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; addr = 23'h400000;
    @(negedge clk);
    checks++; if ({req, berr, dtack} !== 3'b001) begin errors++; $display("FAIL unmap_edge1: req/berr/dtack %b want 001", {req, berr, dtack}); end
    @(negedge clk);
    checks++; if ({req, berr, dtack} !== 3'b001) begin errors++; $display("FAIL unmap_hold: req/berr/dtack %b want 001", {req, berr, dtack}); end
    release_bus();
    @(negedge clk);
    checks++; if ({berr, dtack} !== 2'b11) begin errors++; $display("FAIL unmap_release: berr/dtack %b want 11", {berr, dtack}); end
  endtask

  task automatic test_timeout();
    int reqcycles;
    reqcycles = 0;
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; addr = 23'h080010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req === 1'b1) reqcycles++;
      else break;
    end
    checks++; if (reqcycles != 8) begin errors++; $display("FAIL tmo_req_cycles: got %0d want 8", reqcycles); end
    checks++; if (berr !== 1'b0 || dtack !== 1'b1) begin errors++; $display("FAIL tmo_berr: berr %b dtack %b want 0 1", berr, dtack); end
    release_bus();
    @(negedge clk);
    checks++; if (berr !== 1'b1) begin errors++; $display("FAIL tmo_release: got %b want 1", berr); end
  endtask

  task automatic test_ack_at_limit();
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; addr = 23'h080010;
    repeat (8) @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL lim_req_cycle8: got %b want 1", req); end
    mack = 1'b1; mrdata = 16'hCAFE;
    @(negedge clk);
    mack = 1'b0;
    checks++; if ({req, berr, dtack} !== 3'b011) begin errors++; $display("FAIL lim_ack_wins: req/berr/dtack %b want 011", {req, berr, dtack}); end
    @(negedge clk);
    checks++; if ({berr, dtack} !== 2'b10) begin errors++; $display("FAIL lim_dtack: berr/dtack %b want 10", {berr, dtack}); end
    checks++; if (data_r !== 16'hCAFE) begin errors++; $display("FAIL lim_rdata: got %h want CAFE", data_r); end
    release_bus();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_cycle();
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; addr = 23'h080004;
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b want 1", req); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({req, dtack, berr} !== 3'b011) begin errors++; $display("FAIL rstmid_outputs: req/dtack/berr %b want 011", {req, dtack, berr}); end
    rst = 1'b0; release_bus();
    @(negedge clk);
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; addr = 23'h080004;
    @(negedge clk);
    checks++; if (req !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL rstmid_fresh_req: req %b sel %b want 1 1", req, sel); end
    mack = 1'b1; mrdata = 16'h5A5A;
    @(negedge clk);
    mack = 1'b0;
    @(negedge clk);
    checks++; if (dtack !== 1'b0 || data_r !== 16'h5A5A) begin errors++; $display("FAIL rstmid_fresh_done: dtack %b rdata %h want 0 5A5A", dtack, data_r); end
    release_bus();
    @(negedge clk);
  endtask

  task automatic test_abort();
    as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; addr = 23'h080020;
    @(negedge clk);
    release_bus();
    @(negedge clk);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL abort_req_kept: got %b want 1", req); end
    mack = 1'b1; mrdata = 16'h0F0F;
    @(negedge clk);
    mack = 1'b0;
    checks++; if ({req, dtack, berr} !== 3'b011) begin errors++; $display("FAIL abort_done: req/dtack/berr %b want 011", {req, dtack, berr}); end
    @(negedge clk);
    checks++; if ({req, dtack, berr} !== 3'b011) begin errors++; $display("FAIL abort_idle: req/dtack/berr %b want 011", {req, dtack, berr}); end
  endtask

  task automatic test_no_strobes();
    as_n = 1'b0; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1; addr = 23'h080000;
    repeat (2) @(negedge clk);
    checks++; if ({req, dtack, berr} !== 3'b011) begin errors++; $display("FAIL nostrobe_idle: req/dtack/berr %b want 011", {req, dtack, berr}); end
    release_bus();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ram_write();
    test_rom_read();
    test_rom_write();
    test_unmapped();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_cycle();
    test_abort();
    test_no_strobes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_ctrl.md
Name: m68k_bus_ctrl

Overview:
- Bus-cycle responder directly downstream of the fx68k core.
- Decodes AS/UDS/LDS/RW/address into single-word requests on the internal synchronous memory port, returns read data and generates DTACKn.
- Generates BERRn for unmapped addresses and for stalled accesses.
- Runs on the CPU clock.

Parameters:
- ROM_BASE, 24'h000000, byte base of ROM region.
- ROM_SIZE_LOG2, 16, ROM region size is 2**N bytes.
- RAM_BASE, 24'h100000, byte base of RAM region.
- RAM_SIZE_LOG2, 17, RAM region size is 2**N bytes.
- TIMEOUT_CYCLES, 64, cycles in WAIT_ACK before bus error; valid range 2..255.

Ports:
- i_CLOCK  in  1  system clock, shared with the CPU
- i_RESET  in  1  synchronous, active-high reset
- i_AS  in  1  CPU address strobe, active low
- i_UDS  in  1  upper data strobe (D15..8), active low
- i_LDS  in  1  lower data strobe (D7..0), active low
- i_RW  in  1  1 = read, 0 = write
- i_ADDR  in  23  CPU word address A23..A1
- i_DATA_W  in  16  CPU write data
- o_DATA_R  out  16  read data to CPU
- o_DTACK  out  1  data acknowledge to CPU, active low
- o_BERR  out  1  bus error to CPU, active low
- o_MEM_REQ  out  1  memory request, level, held until ack
- o_MEM_WE  out  1  1 = write
- o_MEM_SEL  out  1  0 = ROM, 1 = RAM
- o_MEM_BE  out  2  byte enables {upper, lower}, active high
- o_MEM_ADDR  out  23  word address within the CPU space
- o_MEM_WDATA  out  16  write data
- i_MEM_ACK  in  1  one-cycle completion pulse
- i_MEM_RDATA  in  16  read data, valid when i_MEM_ACK = 1

Behaviour:
- Reset values:
  - o_DTACK = 1, o_BERR = 1.
  - o_MEM_REQ = 0, o_MEM_WE = 0, o_MEM_SEL = 0, o_MEM_BE = 0.
  - o_MEM_ADDR = 0, o_MEM_WDATA = 0, o_DATA_R = 0.
  - State = IDLE; timeout counter = 0.
- Reset has priority over every transition, including mid-cycle. A pending memory request is dropped; the memory port tolerates this.
- Cycle start: edge i_AS=0 while in IDLE and (i_UDS=0 or i_LDS=0).
  - i_AS low with both strobes high: stay IDLE. This covers the read-modify-write gap and the interrupt-ack slot.
- IDLE -> decode, same edge. Latch addr/RW/BE/wdata into the o_MEM_* registers.
  - ROM hit, read: go to WAIT_ACK with o_MEM_REQ=1 on the next cycle.
  - ROM hit, write: no memory access; go to ACK (write-protected, silently ignored).
  - RAM hit: go to WAIT_ACK.
  - Miss: go to BERR.
- Region hit rule: (byte_addr >> SIZE_LOG2) == (BASE >> SIZE_LOG2), where byte_addr = {i_ADDR, 1'b0}. ROM is checked first on overlap.
- WAIT_ACK:
  - o_MEM_REQ = 1; counter increments each cycle.
  - i_MEM_ACK = 1: capture i_MEM_RDATA into o_DATA_R (reads only; writes leave it unchanged), drop REQ, go to ACK.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: drop REQ, go to BERR.
  - Ack on the same cycle as the timeout: ack wins.
- ACK:
  - o_DTACK = 0 from the cycle after entry until the first edge with i_AS = 1. That edge sets o_DTACK = 1 and goes to IDLE.
  - o_DATA_R is stable throughout ACK.
- BERR: o_BERR = 0 until the first edge with i_AS = 1, then o_BERR = 1 and go to IDLE. o_DTACK is never asserted in BERR.
- Abort: i_AS = 1 while in WAIT_ACK.
  - Keep REQ until ack or timeout, then go to IDLE with no DTACK/BERR pulse.
  - A new i_AS = 0 is not accepted until IDLE is reached.
- Latency: a zero-wait memory (ack on the first REQ cycle) gives o_DTACK low 3 edges after the edge that samples i_AS = 0.
- o_MEM_BE = {~i_UDS, ~i_LDS}, latched at cycle start.
- o_MEM_ADDR is the full i_ADDR; the memory side masks to its own region size.
- Counter width: 8 bits. It is cleared on every entry to WAIT_ACK.

Decomposition:
- Package m68k_bus_pkg holds:
  - state enum (IDLE, WAIT_ACK, ACK, BERR);
  - region select constants SEL_ROM/SEL_RAM;
  - a function region_hit(addr, base, size_log2).
- No sub-module; single FSM plus datapath registers.

Test Plan:
- RAM word write: ROM_BASE=0, RAM_BASE=24'h100000, AS/UDS/LDS low, RW=0, ADDR=24'h100010>>1, data 16'hBEEF, mem acks 2 cycles after REQ -> REQ/WE=1, BE=2'b11, WDATA=BEEF; DTACK low until AS rises, then high next edge.
- ROM byte read: address 24'h000004, UDS only, mem returns 16'h1234 with zero wait -> BE=2'b10, SEL=0, o_DATA_R=1234 and DTACK low 3 edges after the AS sample.
- ROM write: address 24'h000000, RW=0 -> no REQ ever asserted, DTACK asserted, o_DATA_R unchanged.
- Unmapped address 24'h800000 -> no REQ, BERR low until AS high, DTACK stays high.
- Stalled RAM read, TIMEOUT_CYCLES=8, no ack -> REQ high exactly 8 cycles then BERR low. Repeat with ack on cycle 8 -> DTACK, no BERR.
- i_RESET high while in WAIT_ACK -> next edge: REQ=0, DTACK=1, BERR=1, state IDLE. A fresh RAM read after reset completes normally.
